// File: rtl/digitron_scan_driver.sv
// Six-digit multiplexed 7-segment driver: sequential double-dabble conversion of a
// 20-bit value, leading-zero blanking, decimal points and a blinking cursor digit.
module digitron_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] number_in,
  input  logic [5:0]  blink_mask,
  input  logic [5:0]  point_mask,
  output logic [7:0]  seg_out,
  output logic [5:0]  dig_sel,
  output logic        overflow
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]         state_r;
  logic [19:0]        conv_src_r;
  logic [19:0]        shift_r;
  logic [27:0]        bcd_r;
  logic [4:0]         bit_cnt_r;
  logic [23:0]        disp_bcd_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [2:0]         idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_ph_r;

  logic [27:0] bcd_adj_s;
  logic [3:0]  digit_s [6];
  logic [5:0]  lead_blank_s;
  logic [7:0]  seg_next_s;
  logic [5:0]  dig_next_s;

  function automatic logic [27:0] dabble_adjust(input logic [27:0] bcd);
    logic [27:0] res;
    res = bcd;
    for (int n = 0; n < 7; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end else begin
        res[n*4 +: 4] = bcd[n*4 +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Add-3 correction applied to the accumulator before each shift
  always_comb begin
    bcd_adj_s = dabble_adjust(bcd_r);
  end

  // Conversion FSM; the 7th BCD digit flags values above 999999
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      conv_src_r <= 20'd0;
      shift_r    <= 20'd0;
      bcd_r      <= 28'd0;
      bit_cnt_r  <= 5'd0;
      disp_bcd_r <= 24'd0;
      overflow   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (number_in != conv_src_r) begin
            conv_src_r <= number_in;
            shift_r    <= number_in;
            bcd_r      <= 28'd0;
            bit_cnt_r  <= 5'd0;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_r     <= {bcd_adj_s[26:0], shift_r[19]};
          shift_r   <= {shift_r[18:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + 5'd1;
          if (bit_cnt_r == 5'd19) begin
            state_r <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (bcd_r[27:24] != 4'd0) begin
            disp_bcd_r <= 24'h999999;
            overflow   <= 1'b1;
          end else begin
            disp_bcd_r <= bcd_r[23:0];
            overflow   <= 1'b0;
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Digit dwell counter and scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 3'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      idx_r      <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 1'b1;
    end
  end

  // Blink half-period counter and phase
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= ~blink_ph_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  // Per-digit value and leading-zero blanking (a lit dp at or left of k stops blanking)
  always_comb begin
    logic zero_run;
    logic point_run;
    zero_run  = 1'b1;
    point_run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      digit_s[k]      = disp_bcd_r[(5-k)*4 +: 4];
      zero_run        = zero_run & (digit_s[k] == 4'd0);
      point_run       = point_run | point_mask[k];
      lead_blank_s[k] = (k < 5) ? (zero_run & ~point_run) : 1'b0;
    end
  end

  // Segment pattern for the digit currently selected
  always_comb begin
    dig_next_s = 6'd1 << idx_r;
    if (blink_mask[idx_r] && blink_ph_r) begin
      seg_next_s = 8'h00;
    end else begin
      seg_next_s = {point_mask[idx_r], lead_blank_s[idx_r] ? 7'h00 : seg7(digit_s[idx_r])};
    end
  end

  // Output register with pin polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= {8{SEG_ACTIVE_LOW}};
      dig_sel <= {6{DIG_ACTIVE_LOW}};
    end else begin
      seg_out <= seg_next_s ^ {8{SEG_ACTIVE_LOW}};
      dig_sel <= dig_next_s ^ {6{DIG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_digitron_scan_driver.sv
// Self-checking bench for digitron_scan_driver: directed vector table, multi-cycle
// corner sequences and randomized values/masks checked against an arithmetic model.
module tb_digitron_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] number_in = 20'd0;
  logic [5:0]  blink_mask = 6'd0;
  logic [5:0]  point_mask = 6'd0;
  logic [7:0]  seg_out;
  logic [5:0]  dig_sel;
  logic        overflow;

  int unsigned ecnt;
  int n_pass = 0;
  int n_total = 0;

  digitron_scan_driver #(
    .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .number_in(number_in), .blink_mask(blink_mask),
    .point_mask(point_mask), .seg_out(seg_out), .dig_sel(dig_sel), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Edges since reset release: the output after edge e shows digit ((e-1)/SCAN_DIV)%6
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [19:0] num;
    logic [5:0]  pm;
    int          k;
    logic [7:0]  exp_seg;
    logic        exp_ovf;
  } vec_t;

  function automatic logic [7:0] seg7(input int d);
    logic [7:0] t [10];
    t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return t[d];
  endfunction

  function automatic int model_idx(input int unsigned e);
    return int'(((e - 1) / SCAN_DIV) % 6);
  endfunction

  function automatic logic model_ph(input int unsigned e);
    return (((e - 1) / BLINK_DIV) % 2) == 1;
  endfunction

  function automatic logic [7:0] model_seg(input int unsigned v, input int k,
                                           input logic [5:0] pm, input logic [5:0] bm,
                                           input logic ph);
    int unsigned cv;
    int unsigned p;
    logic [7:0] s;
    logic blank;
    logic [5:0] pm_left;
    cv = (v > 999999) ? 999999 : v;
    p = 1;
    for (int i = 0; i < 5 - k; i++) p = p * 10;
    pm_left = pm & 6'((7'd1 << (k + 1)) - 7'd1);
    blank = (k < 5) && (cv / p == 0) && (pm_left == 6'd0);
    s = blank ? 8'h00 : seg7(int'((cv / p) % 10));
    s[7] = pm[k];
    if (bm[k] && ph) s = 8'h00;
    return s;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model(input string name, input int unsigned v);
    int k;
    k = model_idx(ecnt);
    check({name, "_seg"}, {24'd0, seg_out},
          {24'd0, model_seg(v, k, point_mask, blink_mask, model_ph(ecnt))});
    check({name, "_dig"}, {26'd0, dig_sel}, 32'd1 << k);
    check({name, "_ovf"}, {31'd0, overflow}, {31'd0, v > 999999});
  endtask

  // Advance until the model says digit k (and optionally phase ph) is on the pins
  task automatic wait_k(input string name, input int k, input int ph);
    for (int i = 0; i < 400; i++) begin
      if (model_idx(ecnt) == k && (ph < 0 || int'(model_ph(ecnt)) == ph)) return;
      step();
    end
    n_total++;
    $display("FAIL %s: timeout waiting for digit %0d", name, k);
  endtask

  vec_t vecs [22];

  initial begin
    vecs = '{
      '{20'd123456, 6'b000000, 0, 8'h06, 1'b0}, '{20'd123456, 6'b000000, 1, 8'h5B, 1'b0},
      '{20'd123456, 6'b000000, 2, 8'h4F, 1'b0}, '{20'd123456, 6'b000000, 3, 8'h66, 1'b0},
      '{20'd123456, 6'b000000, 4, 8'h6D, 1'b0}, '{20'd123456, 6'b000000, 5, 8'h7D, 1'b0},
      '{20'd50,     6'b000000, 0, 8'h00, 1'b0}, '{20'd50,     6'b000000, 3, 8'h00, 1'b0},
      '{20'd50,     6'b000000, 4, 8'h6D, 1'b0}, '{20'd50,     6'b000000, 5, 8'h3F, 1'b0},
      '{20'd100,    6'b000100, 0, 8'h00, 1'b0}, '{20'd100,    6'b000100, 1, 8'h00, 1'b0},
      '{20'd100,    6'b000100, 2, 8'hBF, 1'b0}, '{20'd100,    6'b000100, 3, 8'h06, 1'b0},
      '{20'd100,    6'b000100, 4, 8'h3F, 1'b0}, '{20'd100,    6'b000100, 5, 8'h3F, 1'b0},
      '{20'd1000000, 6'b000000, 0, 8'h6F, 1'b1}, '{20'd1000000, 6'b000000, 2, 8'h6F, 1'b1},
      '{20'd1000000, 6'b000000, 5, 8'h6F, 1'b1}, '{20'd7,     6'b000000, 5, 8'h07, 1'b0},
      '{20'd7,      6'b000000, 4, 8'h00, 1'b0}, '{20'd7,      6'b000000, 0, 8'h00, 1'b0}
    };

    // Reset state
    for (int i = 0; i < 3; i++) step();
    check("rst_seg", {24'd0, seg_out}, 32'h0);
    check("rst_dig", {26'd0, dig_sel}, 32'h0);
    check("rst_ovf", {31'd0, overflow}, 32'h0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      if (vecs[i].num != number_in || vecs[i].pm != point_mask) begin
        number_in  = vecs[i].num;
        point_mask = vecs[i].pm;
        for (int c = 0; c < 30; c++) step();
      end
      wait_k("vec", vecs[i].k, -1);
      check($sformatf("vec%0d_seg", i), {24'd0, seg_out}, {24'd0, vecs[i].exp_seg});
      check($sformatf("vec%0d_dig", i), {26'd0, dig_sel}, 32'd1 << vecs[i].k);
      check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end
    point_mask = 6'd0;

    // Cursor blink on the units digit
    number_in  = 20'd5;
    blink_mask = 6'b100000;
    for (int c = 0; c < 30; c++) step();
    wait_k("blink0", 5, 0);
    check("blink_on_seg", {24'd0, seg_out}, 32'h6D);
    wait_k("blink1", 5, 1);
    check("blink_off_seg", {24'd0, seg_out}, 32'h00);
    check("blink_off_dig", {26'd0, dig_sel}, 32'h20);
    blink_mask = 6'd0;
    for (int c = 0; c < 30; c++) step();

    // Input change during SHIFT is ignored until the FSM returns to IDLE
    number_in = 20'd111111;
    step();
    for (int c = 0; c < 5; c++) step();
    number_in = 20'd222222;
    for (int c = 0; c < 18; c++) step();
    for (int c = 0; c < 20; c++) begin
      check("busy_old_seg", {24'd0, seg_out}, 32'h06);
      step();
    end
    for (int c = 0; c < 3; c++) step();
    for (int c = 0; c < 24; c++) begin
      check("busy_new_seg", {24'd0, seg_out}, 32'h5B);
      step();
    end

    // Reset mid-conversion
    number_in = 20'd654321;
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    number_in = 20'd0;
    step();
    check("midrst_seg", {24'd0, seg_out}, 32'h0);
    check("midrst_dig", {26'd0, dig_sel}, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      check_model("midrst_zero", 0);
    end

    // Randomized values and live masks against the model
    for (int it = 0; it < 10; it++) begin
      int unsigned v;
      v = (it % 3 == 0) ? $urandom_range(0, 999) : $urandom_range(0, 1048575);
      number_in = 20'(v);
      for (int c = 0; c < 60; c++) begin
        step();
        if (c >= 25) check_model("rand", v);
        point_mask = 6'($urandom & $urandom);
        blink_mask = 6'($urandom & $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
